// File: rtl/weight_seq_ctrl_pkg.sv
// weight_seq_ctrl_pkg: shared state encoding and counter sizing for the weight sequencer
package weight_seq_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    // Element counter needs at least one bit even for a single-weight neuron
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/weight_seq_ctrl.sv
// weight_seq_ctrl: loads neuron weights from a config bus and streams aligned (x, w) pairs to the MAC
module weight_seq_ctrl
    import weight_seq_ctrl_pkg::*;
#(
    parameter int numWeight    = 3,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [addressWidth-1:0] cfg_addr,
    input  logic [dataWidth-1:0]    cfg_data,
    output logic                    cfg_err,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [dataWidth-1:0]    in_data,
    output logic                    mem_wen,
    output logic [addressWidth-1:0] mem_wadd,
    output logic [dataWidth-1:0]    mem_win,
    output logic                    mem_ren,
    output logic [addressWidth-1:0] mem_radd,
    input  logic [dataWidth-1:0]    mem_wout,
    output logic                    mac_valid,
    output logic [dataWidth-1:0]    mac_x,
    output logic [dataWidth-1:0]    mac_w,
    output logic                    mac_last,
    output logic                    done,
    output logic                    busy
);

    localparam int CW = cnt_width(numWeight);
    localparam logic [CW-1:0] LAST = CW'(numWeight - 1);
    localparam logic [addressWidth:0] NW = (addressWidth + 1)'(numWeight);

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [dataWidth-1:0] x_d, w_hold;
    logic                last_d;
    logic                cfg_acc, in_acc, is_last, in_range;

    // Handshakes, memory port drive and next-state selection
    always_comb begin
        cfg_ready = (state == IDLE);
        in_ready  = (state == IDLE) ? ~cfg_valid : 1'b1;
        cfg_acc   = cfg_valid & cfg_ready;
        in_acc    = in_valid & in_ready;
        is_last   = (cnt == LAST);
        in_range  = ({1'b0, cfg_addr} < NW);
        mem_wen   = cfg_acc & in_range;
        mem_wadd  = cfg_addr;
        mem_win   = cfg_data;
        mem_ren   = in_acc;
        mem_radd  = addressWidth'(cnt);
        state_nxt = state;
        cnt_nxt   = cnt;
        if (in_acc) begin
            cnt_nxt   = is_last ? '0 : cnt + 1'b1;
            state_nxt = is_last ? FLUSH : RUN;
        end else if (state == FLUSH) begin
            state_nxt = IDLE;
        end
    end

    // State, element index, sticky error and the registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cfg_err   <= 1'b0;
            mac_valid <= 1'b0;
            last_d    <= 1'b0;
            x_d       <= '0;
            w_hold    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cfg_err   <= cfg_err | (cfg_acc & ~in_range);
            mac_valid <= in_acc;
            last_d    <= in_acc & is_last;
            if (in_acc) x_d <= in_data;
            if (mac_valid) w_hold <= mem_wout;
        end
    end

    // Read data arrives the cycle after the accept; hold the last weight when no pair is presented
    assign mac_x    = x_d;
    assign mac_w    = mac_valid ? mem_wout : w_hold;
    assign mac_last = last_d;
    assign done     = last_d;
    assign busy     = (state != IDLE);

endmodule

// File: doc/weight_seq_ctrl.md
Name: weight_seq_ctrl

Overview:
Controller for one neuron's weight memory (1-cycle registered read, no reset on contents). Owns the memory's write and read ports. Loads weights from a config bus while idle, then sequences weight reads in lock-step with a streamed input vector. Presents aligned (input, weight) pairs to the neuron MAC, with last/done markers per vector.

Parameters:
numWeight, 3, weights per neuron = input vector length (>=1)
addressWidth, 10, weight memory address width; numWeight <= 2**addressWidth
dataWidth, 16, input/weight word width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when cfg_valid & cfg_ready
cfg_addr  in  addressWidth  weight index to write
cfg_data  in  dataWidth  weight value
cfg_err  out  1  sticky: out-of-range cfg_addr was presented and accepted
in_valid  in  1  input activation valid
in_ready  out  1  input accepted when in_valid & in_ready
in_data  in  dataWidth  input activation, element order 0..numWeight-1
mem_wen  out  1  to weight memory write enable
mem_wadd  out  addressWidth  write address
mem_win  out  dataWidth  write data
mem_ren  out  1  read enable
mem_radd  out  addressWidth  read address
mem_wout  in  dataWidth  read data, valid 1 cycle after mem_ren
mac_valid  out  1  pair valid (MAC always accepts, no backpressure)
mac_x  out  dataWidth  input element
mac_w  out  dataWidth  matching weight
mac_last  out  1  pair is element numWeight-1
done  out  1  1-cycle pulse, coincident with mac_last
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, cnt=0, mac_valid=0, mac_last=0, done=0, cfg_err=0, mac_x/mac_w=0. Memory contents not cleared.
- States: IDLE, RUN, FLUSH; cnt = next element index, width clog2(numWeight), minimum 1.
- IDLE: cfg_ready=1; in_ready=~cfg_valid (config has priority). Accepted cfg: if cfg_addr<numWeight, mem_wen=1 combinationally, mem_wadd=cfg_addr, mem_win=cfg_data; else no write and cfg_err<=1. Accepted input -> read element cnt.
- RUN: cfg_ready=0, in_ready=1.
- FLUSH, one cycle after final element accepted: cfg_ready=0, in_ready=1, allowing back-to-back vectors.
- Input accept, any state: mem_ren=1, mem_radd=cnt combinationally; x_d<=in_data; last_d<=(cnt==numWeight-1).
  - If cnt==numWeight-1: cnt<=0, next state FLUSH.
  - Else: cnt<=cnt+1, next state RUN.
- RUN with no accept: hold, bubbles allowed, no timeout.
- FLUSH with no accept: next state IDLE.
- Output stage, registered: the cycle after an accept, mac_valid=1, mac_x=x_d, mac_w=mem_wout, mac_last=last_d, done=last_d. Otherwise mac_valid, mac_last and done are 0.
- mac_x/mac_w hold their value when mac_valid=0.
- Latency: input accept -> mac_valid is exactly 1 cycle.
- numWeight=1: every accept goes IDLE/FLUSH -> FLUSH, and every pair has mac_last=1.
- Write/read same-cycle conflict is impossible: writes only in IDLE, and reads are blocked in IDLE while cfg_valid=1.
- Reset mid-vector: partial vector is dropped with no done. The next vector starts at element 0.

Decomposition:
- Shared package: state enum (IDLE, RUN, FLUSH) and a clog2-based counter-width function.
- No sub-module needed. The weight memory is instantiated beside this block, not inside it.

Test Plan:
- Config load, numWeight=3: write addrs 0,1,2 = 0x0011,0x0022,0x0033 -> three mem_wen pulses with matching mem_wadd/mem_win; cfg_err=0.
- Out-of-range cfg_addr=3 -> no mem_wen, cfg_err=1 and stays 1 until rst_n.
- Stream x=0x0100,0x0200,0x0300 on consecutive cycles:
  - mem_radd=0,1,2.
  - One cycle later, pairs (0x0100,0x0011), (0x0200,0x0022), (0x0300,0x0033).
  - mac_last and done on the third pair only.
- Bubbles: in_valid pattern 1,0,0,1,1 -> busy held, pairs still in order, done once.
  - Follow with back-to-back second vector through FLUSH: no idle gap, cnt restarts at 0.
- Priority: cfg_valid and in_valid both high in IDLE -> write performed, in_ready=0. Input accepted the next cycle after cfg_valid drops.
- Reset mid-vector after 2 of 3 elements -> outputs 0 immediately. Next full vector yields pairs from element 0, with done after the 3rd.
